// File: rtl/a2d_pkg.sv
// Shared types for the A2D conversion scheduler: FSM states, channel rotation
// index, and the SPI command word builder.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package a2d_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMD   = 3'd1,
    GAP   = 3'd2,
    READ  = 3'd3,
    FAULT = 3'd4
  } state_t;

  // Rotation order is the enum order; the pointer wraps BATT -> LFT.
  typedef enum logic [1:0] {
    LFT   = 2'd0,
    RGHT  = 2'd1,
    STEER = 2'd2,
    BATT  = 2'd3
  } ch_idx_t;

  // Command word: channel number in bits [13:11], everything else zero.
  function automatic logic [15:0] cmd_word(input logic [2:0] chnl);
    return {2'b00, chnl, 11'h000};
  endfunction

endpackage

// File: rtl/a2d_tmr.sv
// Loadable down-counter shared by the inter-transaction gap and the done timeout.
// Latency: load takes effect on the next clock; last is combinational from the count.
// Backpressure: none; en simply freezes the count when low. Saturates at zero.
//   clk, rst   : clock, async active-high reset
//   load       : load load_val (has priority over en)
//   load_val   : value to load
//   en         : decrement by one when nonzero
//   last       : count is 1, i.e. this cycle's decrement reaches zero
module a2d_tmr #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         last
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign last = (cnt == W'(1));

endmodule

// File: rtl/a2d_seq.sv
// Round-robin scheduler sharing one SPI A2D between left/right load cell, steering pot, battery.
// Latency: nxt -> wrt 1 clk; CMD done -> READ wrt GAP_CYC idle clks; READ done -> result/upd 1 clk.
// Backpressure: nxt while busy collapses into one pending request; nxt ignored in FAULT.
//   clk, rst          : clock, async active-high reset
//   nxt, clr_err      : conversion request pulse, fault clear pulse
//   done, rd_data     : SPI master completion pulse and receive word
//   wrt, wt_data      : SPI transaction start pulse and transmit word
//   lft_ld, rght_ld, steer_pot, batt : latest 12-bit results
//   upd               : per-channel write strobe {batt, steer, rght, lft}
//   busy, err         : not IDLE, sticky timeout fault
module a2d_seq
  import a2d_pkg::*;
#(
  parameter int         GAP_CYC  = 2,
  parameter int         TIMEOUT  = 4096,
  parameter logic [2:0] CH_LFT   = 3'd0,
  parameter logic [2:0] CH_RGHT  = 3'd4,
  parameter logic [2:0] CH_STEER = 3'd5,
  parameter logic [2:0] CH_BATT  = 3'd6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nxt,
  input  logic        clr_err,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] wt_data,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] steer_pot,
  output logic [11:0] batt,
  output logic [3:0]  upd,
  output logic        busy,
  output logic        err
);

  state_t     state, state_nxt;
  ch_idx_t    ptr;
  logic       pend;
  logic [2:0] chnl;

  logic        launch;    // IDLE starts the command transaction
  logic        rd_wrt;    // GAP expires, start the read transaction
  logic        cmd_done;
  logic        rd_done;
  logic        tmo;       // timeout fires with no done this cycle
  logic        tmr_load;
  logic [15:0] tmr_val;
  logic        tmr_en;
  logic        tmr_last;

  // Upper receive bits carry no conversion data.
  logic rd_unused;
  assign rd_unused = ^rd_data[15:12];

  a2d_tmr #(.W(16)) u_tmr (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .last     (tmr_last)
  );

  always_comb begin
    chnl = CH_LFT;
    case (ptr)
      LFT:     chnl = CH_LFT;
      RGHT:    chnl = CH_RGHT;
      STEER:   chnl = CH_STEER;
      BATT:    chnl = CH_BATT;
      default: chnl = CH_LFT;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic. done is checked before the timeout so a late done still wins.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (nxt || pend) state_nxt = CMD;
      CMD: begin
        if (done)          state_nxt = GAP;
        else if (tmr_last) state_nxt = FAULT;
      end
      GAP:     if (tmr_last) state_nxt = READ;
      READ: begin
        if (done)          state_nxt = IDLE;
        else if (tmr_last) state_nxt = FAULT;
      end
      FAULT:   if (clr_err) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    launch   = (state == IDLE) && (nxt || pend);
    rd_wrt   = (state == GAP) && tmr_last;
    cmd_done = (state == CMD) && done;
    rd_done  = (state == READ) && done;
    tmo      = ((state == CMD) || (state == READ)) && !done && tmr_last;
    tmr_load = launch || rd_wrt || cmd_done;
    tmr_val  = cmd_done ? 16'(GAP_CYC) : 16'(TIMEOUT);
    tmr_en   = (state == CMD) || (state == GAP) || (state == READ);
    busy     = (state != IDLE);
  end

  // Datapath: SPI word, pending flag, fault flag, pointer and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrt       <= 1'b0;
      wt_data   <= 16'h0000;
      pend      <= 1'b0;
      err       <= 1'b0;
      ptr       <= LFT;
      upd       <= 4'b0000;
      lft_ld    <= 12'h000;
      rght_ld   <= 12'h000;
      steer_pot <= 12'h000;
      batt      <= 12'h000;
    end else begin
      wrt <= launch || rd_wrt;
      upd <= 4'b0000;

      // The word is only reloaded at launch so it stays put through GAP and READ.
      if (launch) wt_data <= cmd_word(chnl);

      // A request arriving while busy (including the cycle READ finishes) is
      // remembered once; FAULT drops requests.
      if (launch || tmo)
        pend <= 1'b0;
      else if (nxt && (state != IDLE) && (state != FAULT))
        pend <= 1'b1;

      if (tmo)
        err <= 1'b1;
      else if ((state == FAULT) && clr_err)
        err <= 1'b0;

      if (rd_done) begin
        case (ptr)
          LFT:     begin lft_ld    <= rd_data[11:0]; upd <= 4'b0001; end
          RGHT:    begin rght_ld   <= rd_data[11:0]; upd <= 4'b0010; end
          STEER:   begin steer_pot <= rd_data[11:0]; upd <= 4'b0100; end
          BATT:    begin batt      <= rd_data[11:0]; upd <= 4'b1000; end
          default: upd <= 4'b0000;
        endcase
        ptr <= ch_idx_t'(ptr + 2'd1);
      end
    end
  end

endmodule

// File: tb/tb_a2d_seq.sv
module tb_a2d_seq;

  localparam int SPI_LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        nxt;
  logic        clr_err;
  logic        done;
  logic [15:0] rd_data;
  logic        wrt;
  logic [15:0] wt_data;
  logic [11:0] lft_ld, rght_ld, steer_pot, batt;
  logic [3:0]  upd;
  logic        busy;
  logic        err;

  a2d_seq #(
    .GAP_CYC (2),
    .TIMEOUT (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .nxt       (nxt),
    .clr_err   (clr_err),
    .done      (done),
    .rd_data   (rd_data),
    .wrt       (wrt),
    .wt_data   (wt_data),
    .lft_ld    (lft_ld),
    .rght_ld   (rght_ld),
    .steer_pot (steer_pot),
    .batt      (batt),
    .upd       (upd),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]  mask;
    logic [11:0] val;
  } upd_exp_t;

  upd_exp_t    upd_q[$];
  logic [15:0] wt_q[$];
  logic [15:0] rsp_q[$];
  int          wrt_c[$], done_c[$], upd_c[$], nxt_c[$];
  logic [15:0] wt_tbl [4];
  logic        hold_read = 1'b0;
  logic        wt_changed = 1'b0;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // SPI master model: done SPI_LAT clocks after each wrt; read transactions
  // return the next queued response, command transactions return junk.
  initial begin : spi_model
    logic        par;
    logic        send;
    logic [15:0] word;
    par = 1'b0;
    done = 1'b0;
    rd_data = 16'h0000;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        par = 1'b0;
      end else if (wrt) begin
        if (!par) begin
          word = 16'hF5A5;
          send = 1'b1;
        end else begin
          send = !hold_read;
          word = 16'h0000;
          if (send && rsp_q.size() > 0) word = rsp_q.pop_front();
        end
        par = ~par;
        if (send) begin
          repeat (SPI_LAT) @(negedge clk);
          rd_data = word;
          done = 1'b1;
          @(negedge clk);
          done = 1'b0;
          rd_data = 16'h0BAD;
        end
      end
    end
  end

  // Scoreboard monitor and event recorder.
  initial begin : monitor
    logic        in_txn;
    logic [15:0] held;
    upd_exp_t    e;
    logic [11:0] sel;
    in_txn = 1'b0;
    held = 16'h0000;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        in_txn = 1'b0;
      end else begin
        if (nxt) nxt_c.push_back(cyc);
        if (wrt) begin
          wrt_c.push_back(cyc);
          held = wt_data;
          in_txn = 1'b1;
          if (wt_q.size() == 0) chk("wrt_unexpected", {31'b0, wrt}, 32'd0);
          else chk("wt_data", {16'b0, wt_data}, {16'b0, wt_q.pop_front()});
        end else if (in_txn && (wt_data !== held)) begin
          wt_changed = 1'b1;
        end
        if (done) begin
          done_c.push_back(cyc);
          in_txn = 1'b0;
        end
        if (upd != 4'b0000) begin
          upd_c.push_back(cyc);
          if (upd_q.size() == 0) begin
            chk("upd_unexpected", {28'b0, upd}, 32'd0);
          end else begin
            e = upd_q.pop_front();
            chk("upd_mask", {28'b0, upd}, {28'b0, e.mask});
            case (e.mask)
              4'b0001: sel = lft_ld;
              4'b0010: sel = rght_ld;
              4'b0100: sel = steer_pot;
              default: sel = batt;
            endcase
            chk("upd_val", {20'b0, sel}, {20'b0, e.val});
          end
        end
      end
    end
  end

  task automatic clear_rec();
    wrt_c.delete(); done_c.delete(); upd_c.delete(); nxt_c.delete();
    wt_changed = 1'b0;
  endtask

  task automatic pulse_nxt();
    @(negedge clk); nxt = 1'b1;
    @(negedge clk); nxt = 1'b0;
  endtask

  // Wait until busy has been low for three consecutive samples.
  task automatic wait_idle(input int bound);
    int quiet = 0;
    for (int i = 0; i < bound && quiet < 3; i++) begin
      @(posedge clk); #1;
      if (!busy) quiet++;
      else quiet = 0;
    end
    if (quiet < 3) chk("idle_timeout", quiet, 32'd3);
  endtask

  task automatic do_conv(input int idx, input logic [15:0] rsp);
    upd_exp_t e;
    wt_q.push_back(wt_tbl[idx]);
    wt_q.push_back(wt_tbl[idx]);
    rsp_q.push_back(rsp);
    e.mask = 4'(1 << idx);
    e.val  = rsp[11:0];
    upd_q.push_back(e);
    pulse_nxt();
    wait_idle(300);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    logic [11:0] t1_vals [4];
    int w_read, err_cyc, n_wrt, wrt_before;
    logic got;

    wt_tbl[0] = 16'h0000; wt_tbl[1] = 16'h2000;
    wt_tbl[2] = 16'h2800; wt_tbl[3] = 16'h3000;
    t1_vals[0] = 12'h123; t1_vals[1] = 12'h456;
    t1_vals[2] = 12'h789; t1_vals[3] = 12'hABC;

    rst = 1'b1; nxt = 1'b0; clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_lft", {20'b0, lft_ld}, 0);
    chk("rst_rght", {20'b0, rght_ld}, 0);
    chk("rst_steer", {20'b0, steer_pot}, 0);
    chk("rst_batt", {20'b0, batt}, 0);
    chk("rst_upd", {28'b0, upd}, 0);
    chk("rst_wrt", {31'b0, wrt}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_err", {31'b0, err}, 0);
    chk("rst_wt_data", {16'b0, wt_data}, 0);
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: full rotation
    for (int i = 0; i < 4; i++) do_conv(i, {4'h0, t1_vals[i]});
    chk("t1_lft", {20'b0, lft_ld}, 32'h123);
    chk("t1_rght", {20'b0, rght_ld}, 32'h456);
    chk("t1_steer", {20'b0, steer_pot}, 32'h789);
    chk("t1_batt", {20'b0, batt}, 32'hABC);

    // 2: three extra nxt while busy -> exactly one extra conversion (rght)
    clear_rec();
    begin
      upd_exp_t e;
      wt_q.push_back(16'h0000); wt_q.push_back(16'h0000);
      wt_q.push_back(16'h2000); wt_q.push_back(16'h2000);
      rsp_q.push_back(16'h0111); rsp_q.push_back(16'h0222);
      e.mask = 4'b0001; e.val = 12'h111; upd_q.push_back(e);
      e.mask = 4'b0010; e.val = 12'h222; upd_q.push_back(e);
    end
    pulse_nxt();
    for (int k = 0; k < 3; k++) begin
      repeat (2) @(negedge clk);
      nxt = 1'b1;
      @(negedge clk); nxt = 1'b0;
    end
    wait_idle(300);
    repeat (20) @(posedge clk);
    #1;
    chk("t2_wrt_count", wrt_c.size(), 32'd4);
    chk("t2_upd_count", upd_c.size(), 32'd2);
    chk("t2_busy_low", {31'b0, busy}, 0);
    chk("t2_lft", {20'b0, lft_ld}, 32'h111);
    chk("t2_rght", {20'b0, rght_ld}, 32'h222);

    // 3: gap and strobe timing on steer
    @(negedge clk);
    clear_rec();
    do_conv(2, 16'h03C3);
    chk("t3_wrt_count", wrt_c.size(), 32'd2);
    chk("t3_done_count", done_c.size(), 32'd2);
    chk("t3_upd_count", upd_c.size(), 32'd1);
    if (wrt_c.size() == 2 && done_c.size() == 2 && upd_c.size() == 1 && nxt_c.size() == 1) begin
      chk("t3_nxt_to_wrt", wrt_c[0] - nxt_c[0], 32'd0);
      chk("t3_gap", wrt_c[1] - done_c[0], 32'd2);
      chk("t3_wrt_spacing", wrt_c[1] - wrt_c[0], 32'(SPI_LAT + 2));
      chk("t3_done_to_upd", upd_c[0] - done_c[1], 32'd0);
    end
    chk("t3_wt_stable", {31'b0, wt_changed}, 0);

    // 4: read done withheld on batt -> timeout fault
    @(negedge clk);
    clear_rec();
    wt_q.push_back(16'h3000); wt_q.push_back(16'h3000);
    hold_read = 1'b1;
    pulse_nxt();
    n_wrt = 1; // launch wrt was seen on the edge before pulse_nxt returned
    w_read = -1;
    for (int i = 0; i < 60 && w_read < 0; i++) begin
      @(posedge clk); #1;
      if (wrt) begin
        n_wrt++;
        if (n_wrt == 2) w_read = cyc;
      end
    end
    if (w_read < 0) chk("t4_read_wrt_timeout", n_wrt, 32'd2);
    err_cyc = -1;
    for (int i = 0; i < 40 && err_cyc < 0; i++) begin
      if (err) err_cyc = cyc;
      else begin @(posedge clk); #1; end
    end
    if (err) err_cyc = cyc;
    chk("t4_err", {31'b0, err}, 32'd1);
    chk("t4_tmo_cycles", err_cyc - w_read, 32'd16);
    chk("t4_batt_kept", {20'b0, batt}, 32'hABC);
    chk("t4_busy_fault", {31'b0, busy}, 32'd1);
    chk("t4_no_upd", upd_c.size(), 32'd0);
    hold_read = 1'b0;
    wrt_before = wrt_c.size();
    pulse_nxt();
    repeat (10) @(posedge clk);
    #1;
    chk("t4_nxt_ignored", wrt_c.size(), 32'(wrt_before));
    chk("t4_err_sticky", {31'b0, err}, 32'd1);
    @(negedge clk); clr_err = 1'b1;
    @(posedge clk); #1;
    chk("t4_clr_err", {31'b0, err}, 0);
    chk("t4_clr_idle", {31'b0, busy}, 0);
    @(negedge clk); clr_err = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("t4_no_pending", wrt_c.size(), 32'(wrt_before));
    do_conv(3, 16'h0DEF);
    chk("t4_batt_retry", {20'b0, batt}, 32'hDEF);

    // 6: upper rd_data bits dropped (lft)
    do_conv(0, 16'hFFFF);
    chk("t6_lft_fff", {20'b0, lft_ld}, 32'hFFF);

    // 5: reset mid-GAP on rght, then restart from lft
    @(negedge clk);
    wt_q.push_back(16'h2000);
    pulse_nxt();
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); #1;
      if (done) got = 1'b1;
    end
    if (!got) chk("t5_cmd_done_timeout", {31'b0, got}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t5_lft", {20'b0, lft_ld}, 0);
    chk("t5_rght", {20'b0, rght_ld}, 0);
    chk("t5_steer", {20'b0, steer_pot}, 0);
    chk("t5_batt", {20'b0, batt}, 0);
    chk("t5_upd", {28'b0, upd}, 0);
    chk("t5_wrt", {31'b0, wrt}, 0);
    chk("t5_busy", {31'b0, busy}, 0);
    chk("t5_err", {31'b0, err}, 0);
    chk("t5_wt_data", {16'b0, wt_data}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    do_conv(0, 16'h05A5);
    chk("t5_lft_after", {20'b0, lft_ld}, 32'h5A5);

    repeat (5) @(posedge clk);
    #1;
    chk("sb_upd_drained", upd_q.size(), 0);
    chk("sb_wt_drained", wt_q.size(), 0);
    chk("wt_stable_all", {31'b0, wt_changed}, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
